sys_cmd_decoder: RTL and testbench
==================================

// Module: sys_cmd_decoder
// PURPOSE
//  Command front end feeding the register file. Consumes UART RX bytes, decodes
//  write (0xAA, addr, data) and read (0xBB, addr) frames, and drives WrEn/RdEn/
//  Address/WrData. Read results go back to the UART TX side with a busy handshake.
// PARAMETERS
//  DATA_WIDTH   8      byte / register data width
//  ADDR_WIDTH   4      register file address width
//  CMD_WR       8'hAA  write-frame opcode
//  CMD_RD       8'hBB  read-frame opcode
//  RD_TIMEOUT   4      cycles to wait for RdData_VLD after RdEn
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst          in   1           asynchronous, active-high reset
//  RX_P_DATA    in   DATA_WIDTH  received byte
//  RX_D_VLD     in   1           one-cycle strobe, RX_P_DATA valid
//  RdData       in   DATA_WIDTH  register file read data
//  RdData_VLD   in   1           register file read-valid strobe
//  TX_BUSY      in   1           UART TX busy; TX_D_VLD must not issue while high
//  WrEn         out  1           register file write enable (1-cycle pulse)
//  RdEn         out  1           register file read enable (1-cycle pulse)
//  Address      out  ADDR_WIDTH  register file address
//  WrData       out  DATA_WIDTH  register file write data
//  TX_P_DATA    out  DATA_WIDTH  byte to transmit
//  TX_D_VLD     out  1           one-cycle strobe, TX_P_DATA valid
//  CMD_ERR      out  1           one-cycle pulse: bad opcode, dropped byte or read timeout
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, FSM in IDLE, timeout counter 0.
//  - FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
//  - IDLE: on RX_D_VLD, CMD_WR -> WR_ADDR; CMD_RD -> RD_ADDR; other value ->
//    CMD_ERR pulse next cycle, stay IDLE.
//  - WR_ADDR: on RX_D_VLD, latch Address = RX_P_DATA[ADDR_WIDTH-1:0] (upper bits
//    ignored) -> WR_DATA.
//  - WR_DATA: on RX_D_VLD, WrData = RX_P_DATA and WrEn = 1 on the next cycle only
//    -> IDLE. Address and WrData hold until the next frame overwrites them.
//  - RD_ADDR: on RX_D_VLD, latch Address and pulse RdEn one cycle -> RD_WAIT,
//    clear the timeout counter.
//  - RD_WAIT: on RdData_VLD, capture RdData into the TX buffer -> TX_SEND. If no
//    RdData_VLD within RD_TIMEOUT cycles after the RdEn pulse: CMD_ERR pulse -> IDLE.
//  - TX_SEND: when TX_BUSY=0, drive TX_P_DATA and pulse TX_D_VLD one cycle -> IDLE.
//    While TX_BUSY=1, wait indefinitely with TX_P_DATA held.
//  - WrEn and RdEn are never high in the same cycle.
//  - RX_D_VLD in RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse, state unchanged.
//  - Frame bytes have no inter-byte timeout. A stalled frame waits in its state.
//  - rst mid-frame: frame abandoned, any pending WrEn/RdEn/TX_D_VLD is not issued.
//  - RdData_VLD outside RD_WAIT is ignored.
// STRUCTURE
//  - Shared package sys_pkg: CMD_WR/CMD_RD opcode constants and the FSM state
//    enum (3-bit encoding), reused by the ALU-command extension.
//  - Single module. The timeout counter is inline (clog2(RD_TIMEOUT+1) bits).
//    No sub-module.
// TESTING
//  1 Write: RX AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C; CMD_ERR=0.
//  2 Read: RX BB,02; model returns RdData=0x81 one cycle after RdEn
//    -> TX_D_VLD with TX_P_DATA=0x81.
//  3 Back-pressure: read with TX_BUSY=1 for 10 cycles -> TX_D_VLD is issued
//    exactly 1 cycle after TX_BUSY falls, with data unchanged.
//  4 Errors: RX 0x55 -> CMD_ERR pulse, FSM stays IDLE. Read with no RdData_VLD ->
//    CMD_ERR after 4 cycles, then a following AA,01,FF write succeeds.
//  5 Address truncation and dropped byte: RX AA,F7,11 -> Address=7. RX 0x22
//    during TX_SEND -> CMD_ERR, and the TX byte is still sent.
//  6 Reset mid-frame: assert rst after AA,03 -> no WrEn. After release, BB,03
//    decodes normally.

Source files
------------

// File: rtl/sys_pkg.sv
// rtl/sys_pkg.sv - shared opcodes and FSM state encoding for the command decoders
package sys_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_TX_SEND = 3'd5
    } state_e;

endpackage

// File: rtl/sys_cmd_decoder_if.sv
// rtl/sys_cmd_decoder_if.sv - UART/register-file bundle seen by the command decoder
interface sys_cmd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  RdData_VLD;
    logic                  TX_BUSY;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  CMD_ERR;

    // Decoder side
    modport slave (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, TX_BUSY,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    // Environment side (UART + register file)
    modport master (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/sys_cmd_decoder.sv
// rtl/sys_cmd_decoder.sv - UART byte-frame decoder driving register file reads/writes
module sys_cmd_decoder
    import sys_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR     = sys_pkg::CMD_WR,
    parameter logic [DATA_WIDTH-1:0] CMD_RD     = sys_pkg::CMD_RD,
    parameter int                    RD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    sys_cmd_decoder_if.slave  bus
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  cmd_err_q, cmd_err_d;

    // Next-state and next-output decode; every output is registered one cycle later
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        cmd_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_WR)      state_d = ST_WR_ADDR;
                    else if (bus.RX_P_DATA == CMD_RD) state_d = ST_RD_ADDR;
                    else                              cmd_err_d = 1'b1;
                end
            end
            ST_WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wr_data_d = bus.RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Counter holds the number of cycles elapsed since the RdEn cycle
                if (bus.RX_D_VLD) cmd_err_d = 1'b1;
                if (bus.RdData_VLD) begin
                    tx_data_d = bus.RdData;
                    state_d   = ST_TX_SEND;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TX_SEND: begin
                if (bus.RX_D_VLD) cmd_err_d = 1'b1;
                if (!bus.TX_BUSY) begin
                    tx_vld_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame and pending strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_vld_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_vld_q  <= tx_vld_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.Address   = addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// tb/tb_sys_cmd_decoder.sv - randomized and directed self-checking bench for sys_cmd_decoder
module tb_sys_cmd_decoder;

    localparam int RD_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    sys_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sys_cmd_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .CMD_WR(8'hAA), .CMD_RD(8'hBB), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference: frames as byte lists ----------------
    logic [7:0] frame[$];
    logic [7:0] fb;
    bit         rd_pending = 0, tx_pending = 0;
    int         rd_age = 0;
    bit         e_wr = 0, e_rd = 0, e_txv = 0, e_err = 0;
    logic [3:0] e_addr = '0;
    logic [7:0] e_wd = '0, e_tx = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_wr = 0; e_rd = 0; e_txv = 0; e_err = 0;
            e_addr = '0; e_wd = '0; e_tx = '0;
            frame.delete();
            rd_pending = 0; tx_pending = 0; rd_age = 0;
        end else begin
            e_wr = 0; e_rd = 0; e_txv = 0; e_err = 0;
            if (tx_pending) begin
                if (bus.RX_D_VLD) e_err = 1;
                if (!bus.TX_BUSY) begin e_txv = 1; tx_pending = 0; end
            end else if (rd_pending) begin
                if (bus.RX_D_VLD) e_err = 1;
                if (bus.RdData_VLD) begin
                    e_tx = bus.RdData; tx_pending = 1; rd_pending = 0;
                end else if (rd_age >= RD_TIMEOUT) begin
                    e_err = 1; rd_pending = 0;
                end else rd_age++;
            end else if (bus.RX_D_VLD) begin
                frame.push_back(bus.RX_P_DATA);
                if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
                    e_err = 1; frame.delete();
                end else begin
                    if (frame.size() == 2) begin fb = frame[1]; e_addr = fb[3:0]; end
                    if (frame[0] == 8'hAA && frame.size() == 3) begin
                        e_wd = frame[2]; e_wr = 1; frame.delete();
                    end else if (frame[0] == 8'hBB && frame.size() == 2) begin
                        e_rd = 1; rd_pending = 1; rd_age = 0; frame.delete();
                    end
                end
            end
        end
    end

    // Compare every cycle, mid-cycle
    always @(negedge clk) begin
        chk("WrEn", bus.WrEn, e_wr);
        chk("RdEn", bus.RdEn, e_rd);
        chk("Address", bus.Address, e_addr);
        chk("WrData", bus.WrData, e_wd);
        chk("TX_P_DATA", bus.TX_P_DATA, e_tx);
        chk("TX_D_VLD", bus.TX_D_VLD, e_txv);
        chk("CMD_ERR", bus.CMD_ERR, e_err);
        chk("WrEn_RdEn_exclusive", bus.WrEn & bus.RdEn, 0);
    end

    // ---------------- event recorder for directed literal checks ----------------
    int         wr_count = 0, tx_count = 0, err_count = 0;
    int         tx_cyc = 0, err_cyc = 0, rden_cyc = 0;
    logic [3:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0, last_tx = '0;

    always @(negedge clk) begin
        if (bus.WrEn) begin wr_count++; last_wr_addr = bus.Address; last_wr_data = bus.WrData; end
        if (bus.RdEn) rden_cyc = cyc;
        if (bus.TX_D_VLD) begin tx_count++; last_tx = bus.TX_P_DATA; tx_cyc = cyc; end
        if (bus.CMD_ERR) begin err_count++; err_cyc = cyc; end
    end

    // ---------------- register file responder ----------------
    int         resp_delay = 1;
    logic [7:0] resp_data = 8'h00;
    int         countdown = 0;

    always @(negedge clk) begin
        if (rst) countdown = 0;
        else if (bus.RdEn && resp_delay > 0) countdown = resp_delay;
    end

    always @(posedge clk) begin
        #1;
        bus.RdData_VLD = 1'b0;
        if (rst) countdown = 0;
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                bus.RdData_VLD = 1'b1;
                bus.RdData     = resp_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rx(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge clk); #1;
        bus.RX_D_VLD  = 1'b0;
    endtask

    int w0, t0, e0, fall;
    int r;

    initial begin
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_BUSY   = 1'b0;
        rst = 1'b1;
        idle(3);
        chk("reset_WrEn", bus.WrEn, 0);
        chk("reset_TX_D_VLD", bus.TX_D_VLD, 0);
        chk("reset_CMD_ERR", bus.CMD_ERR, 0);
        chk("reset_Address", bus.Address, 0);
        rst = 1'b0;
        idle(2);

        // Write frame
        w0 = wr_count; e0 = err_count;
        rx(8'hAA); rx(8'h05); rx(8'h3C); idle(2);
        chk("wr1_count", wr_count, w0 + 1);
        chk("wr1_addr", last_wr_addr, 4'h5);
        chk("wr1_data", last_wr_data, 8'h3C);
        chk("wr1_no_err", err_count, e0);

        // Read frame, data one cycle after RdEn
        resp_delay = 1; resp_data = 8'h81; t0 = tx_count;
        rx(8'hBB); rx(8'h02); idle(6);
        chk("rd1_tx_count", tx_count, t0 + 1);
        chk("rd1_tx_data", last_tx, 8'h81);
        chk("rd1_addr", bus.Address, 4'h2);

        // Back-pressure: TX_BUSY high for 10 cycles
        bus.TX_BUSY = 1'b1; resp_data = 8'h5A; t0 = tx_count;
        rx(8'hBB); rx(8'h0A); idle(10);
        chk("bp_held", tx_count, t0);
        bus.TX_BUSY = 1'b0; fall = cyc;
        idle(3);
        chk("bp_count", tx_count, t0 + 1);
        chk("bp_latency", tx_cyc, fall + 1);
        chk("bp_data", last_tx, 8'h5A);

        // Bad opcode
        e0 = err_count;
        rx(8'h55); idle(2);
        chk("badop_err", err_count, e0 + 1);

        // Read timeout, then a write
        resp_delay = 0; e0 = err_count;
        rx(8'hBB); rx(8'h06); idle(8);
        chk("tmo_err", err_count, e0 + 1);
        chk("tmo_latency", err_cyc - rden_cyc, RD_TIMEOUT + 1);
        w0 = wr_count;
        rx(8'hAA); rx(8'h01); rx(8'hFF); idle(2);
        chk("post_tmo_wr", wr_count, w0 + 1);
        chk("post_tmo_addr", last_wr_addr, 4'h1);
        chk("post_tmo_data", last_wr_data, 8'hFF);

        // Address truncation
        rx(8'hAA); rx(8'hF7); rx(8'h11); idle(2);
        chk("trunc_addr", last_wr_addr, 4'h7);
        chk("trunc_data", last_wr_data, 8'h11);

        // Dropped byte during TX_SEND
        resp_delay = 1; resp_data = 8'hC3; bus.TX_BUSY = 1'b1;
        t0 = tx_count;
        rx(8'hBB); rx(8'h04); idle(4);
        e0 = err_count;
        rx(8'h22); idle(2);
        chk("drop_err", err_count, e0 + 1);
        bus.TX_BUSY = 1'b0; idle(3);
        chk("drop_tx_count", tx_count, t0 + 1);
        chk("drop_tx_data", last_tx, 8'hC3);

        // Reset mid-frame
        w0 = wr_count;
        rx(8'hAA); rx(8'h03);
        rst = 1'b1; idle(2); rst = 1'b0; idle(2);
        chk("rst_no_wr", wr_count, w0);
        resp_data = 8'h6E; t0 = tx_count;
        rx(8'hBB); rx(8'h03); idle(6);
        chk("rst_rd_count", tx_count, t0 + 1);
        chk("rst_rd_data", last_tx, 8'h6E);
        chk("rst_rd_addr", bus.Address, 4'h3);

        // Randomized traffic
        repeat (600) begin
            bus.TX_BUSY = ($urandom_range(0, 3) == 0);
            resp_delay  = $urandom_range(1, 6);
            resp_data   = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                bus.RX_P_DATA = (r < 4) ? 8'hAA : (r < 7) ? 8'hBB : 8'($urandom);
                bus.RX_D_VLD  = 1'b1;
            end else begin
                bus.RX_D_VLD  = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.RX_D_VLD = 1'b0;
        bus.TX_BUSY  = 1'b0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
